coin_change_payout: RTL

//  Sequential change payout stage downstream of the vending controller. Accepts a refund/change amount in cents.

---
 rtl/coin_change_payout_pkg.sv | 39 +++
 rtl/coin_pulse_timer.sv | 29 ++
 rtl/coin_change_payout.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/coin_change_payout_pkg.sv
// Shared definitions for the coin change payout stage: coin values,
// payout FSM state encoding and the coin-select enumeration.
package coin_pkg;

    localparam int CENTS_QUARTER = 25;
    localparam int CENTS_DIME    = 10;
    localparam int CENTS_NICKEL  = 5;
    localparam int CENTS_PENNY   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } payout_state_e;

    typedef enum logic [2:0] {
        COIN_NONE = 3'd0,
        COIN_Q    = 3'd1,
        COIN_D    = 3'd2,
        COIN_N    = 3'd3,
        COIN_P    = 3'd4
    } coin_sel_e;

    // Cent value of a selected coin; NONE is worth nothing.
    function automatic int unsigned coin_cents(input coin_sel_e coin);
        int unsigned cents;
        case (coin)
            COIN_Q:  cents = CENTS_QUARTER;
            COIN_D:  cents = CENTS_DIME;
            COIN_N:  cents = CENTS_NICKEL;
            COIN_P:  cents = CENTS_PENNY;
            default: cents = 0;
        endcase
        return cents;
    endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// Loadable down-counter used to time both the eject pulse and the idle gap
// that follows it. expire is high whenever the count has reached zero, so a
// load value of K gives K+1 cycles before expire is seen.
module coin_pulse_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/coin_change_payout.sv
// Change payout stage: pays a requested amount greedily (largest coin first),
// one timed solenoid pulse per coin, tracking tube inventories and reporting
// any amount that could not be paid.
// Optional feature: define CHANGE_PENNY_EN to add a penny tube and its eject
// line; without it, amounts are only paid down to a multiple of 5.
module coin_change_payout
    import coin_pkg::*;
#(
    parameter int AMT_W     = 9,
    parameter int TUBE_W    = 4,
    parameter int TUBE_INIT = 10,
    parameter int TUBE_MAX  = 15,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [AMT_W-1:0]  req_amount,
    output logic              req_ready,
    input  logic              refill,
    output logic              eject_quarter,
    output logic              eject_dime,
    output logic              eject_nickel,
`ifdef CHANGE_PENNY_EN
    output logic              eject_penny,
    output logic [TUBE_W-1:0] p_cnt,
`endif
    output logic              done,
    output logic              short,
    output logic [AMT_W-1:0]  remainder,
    output logic [TUBE_W-1:0] q_cnt,
    output logic [TUBE_W-1:0] d_cnt,
    output logic [TUBE_W-1:0] n_cnt
);

    // The timer only ever holds PULSE_CYC-1 or GAP_CYC-1.
    localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    payout_state_e     state_q, state_d;
    coin_sel_e         coin_q, coin_d;
    coin_sel_e         pick;
    logic [AMT_W-1:0]  pick_value;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic [AMT_W-1:0]  remainder_q, remainder_d;
    logic [TUBE_W-1:0] q_cnt_q, q_cnt_d;
    logic [TUBE_W-1:0] d_cnt_q, d_cnt_d;
    logic [TUBE_W-1:0] n_cnt_q, n_cnt_d;
`ifdef CHANGE_PENNY_EN
    logic [TUBE_W-1:0] p_cnt_q, p_cnt_d;
`endif

    logic              timer_load;
    logic [TMR_W-1:0]  timer_value;
    logic              timer_expire;

    // The same counter times the eject pulse and the gap after it.
    coin_pulse_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .expire     (timer_expire)
    );

    // Greedy coin choice from the current remainder and stock; empty tubes are skipped.
    always_comb begin
        pick = COIN_NONE;
        if ((rem_q >= AMT_W'(CENTS_QUARTER)) && (q_cnt_q != '0)) begin
            pick = COIN_Q;
        end else if ((rem_q >= AMT_W'(CENTS_DIME)) && (d_cnt_q != '0)) begin
            pick = COIN_D;
        end else if ((rem_q >= AMT_W'(CENTS_NICKEL)) && (n_cnt_q != '0)) begin
            pick = COIN_N;
`ifdef CHANGE_PENNY_EN
        end else if ((rem_q >= AMT_W'(CENTS_PENNY)) && (p_cnt_q != '0)) begin
            pick = COIN_P;
`endif
        end
        pick_value = AMT_W'(coin_cents(pick));
    end

    // Timer is armed with the pulse length when a coin is picked and with the gap length when the pulse ends.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = TMR_W'(PULSE_CYC - 1);
        if ((state_q == ST_SELECT) && (pick != COIN_NONE)) begin
            timer_load  = 1'b1;
            timer_value = TMR_W'(PULSE_CYC - 1);
        end else if ((state_q == ST_EJECT) && timer_expire) begin
            timer_load  = 1'b1;
            timer_value = TMR_W'(GAP_CYC - 1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; refill in IDLE blocks acceptance of a same-cycle request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!refill && req_valid) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (pick == COIN_NONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EJECT;
                end
            end
            ST_EJECT: begin
                if (timer_expire) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_expire) begin
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: latch the amount on accept, pay one coin per SELECT, capture the leftover on finish.
    always_comb begin
        rem_d       = rem_q;
        remainder_d = remainder_q;
        coin_d      = coin_q;
        q_cnt_d     = q_cnt_q;
        d_cnt_d     = d_cnt_q;
        n_cnt_d     = n_cnt_q;
`ifdef CHANGE_PENNY_EN
        p_cnt_d     = p_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (refill) begin
                    q_cnt_d = TUBE_W'(TUBE_MAX);
                    d_cnt_d = TUBE_W'(TUBE_MAX);
                    n_cnt_d = TUBE_W'(TUBE_MAX);
`ifdef CHANGE_PENNY_EN
                    p_cnt_d = TUBE_W'(TUBE_MAX);
`endif
                end else if (req_valid) begin
                    rem_d = req_amount;
                end
            end
            ST_SELECT: begin
                if (pick != COIN_NONE) begin
                    rem_d  = rem_q - pick_value;
                    coin_d = pick;
                    case (pick)
                        COIN_Q:  q_cnt_d = q_cnt_q - TUBE_W'(1);
                        COIN_D:  d_cnt_d = d_cnt_q - TUBE_W'(1);
                        COIN_N:  n_cnt_d = n_cnt_q - TUBE_W'(1);
`ifdef CHANGE_PENNY_EN
                        COIN_P:  p_cnt_d = p_cnt_q - TUBE_W'(1);
`endif
                        default: ;
                    endcase
                end else begin
                    remainder_d = rem_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, returned to their reset values on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            remainder_q <= '0;
            coin_q      <= COIN_NONE;
            q_cnt_q     <= TUBE_W'(TUBE_INIT);
            d_cnt_q     <= TUBE_W'(TUBE_INIT);
            n_cnt_q     <= TUBE_W'(TUBE_INIT);
`ifdef CHANGE_PENNY_EN
            p_cnt_q     <= TUBE_W'(TUBE_INIT);
`endif
        end else begin
            rem_q       <= rem_d;
            remainder_q <= remainder_d;
            coin_q      <= coin_d;
            q_cnt_q     <= q_cnt_d;
            d_cnt_q     <= d_cnt_d;
            n_cnt_q     <= n_cnt_d;
`ifdef CHANGE_PENNY_EN
            p_cnt_q     <= p_cnt_d;
`endif
        end
    end

    // Outputs decoded from state; only the latched coin's line can be high, and only during EJECT.
    always_comb begin
        req_ready     = (state_q == ST_IDLE) && !refill;
        eject_quarter = (state_q == ST_EJECT) && (coin_q == COIN_Q);
        eject_dime    = (state_q == ST_EJECT) && (coin_q == COIN_D);
        eject_nickel  = (state_q == ST_EJECT) && (coin_q == COIN_N);
`ifdef CHANGE_PENNY_EN
        eject_penny   = (state_q == ST_EJECT) && (coin_q == COIN_P);
        p_cnt         = p_cnt_q;
`endif
        done          = (state_q == ST_DONE);
        short         = (state_q == ST_DONE) && (rem_q != '0);
        remainder     = remainder_q;
        q_cnt         = q_cnt_q;
        d_cnt         = d_cnt_q;
        n_cnt         = n_cnt_q;
    end

endmodule
